// File: rtl/bubble_pkg.sv
// Shared constants, state encoding and read-address decode for the bubble input buffer.
package bubble_pkg;

    localparam int unsigned PAGE_BITS  = 584;
    localparam int unsigned LANE_AW    = 10;
    localparam int unsigned LANE_DEPTH = 1 << LANE_AW;
    localparam int unsigned CNT_W      = 10;
    localparam int unsigned ACC_W      = 3;
    localparam int unsigned CYC_W      = 13;
    localparam int unsigned RADDR_W    = 15;
    localparam int unsigned RLANE_W    = 13;
    localparam int unsigned NUM_LANES  = 4;

    localparam logic [ACC_W-1:0] BOOT    = 3'b110;
    localparam logic [ACC_W-1:0] USER    = 3'b111;
    localparam logic [ACC_W-1:0] USER_WR = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_HOLD    = 2'd2
    } ibuf_state_t;

    typedef struct packed {
        logic [RLANE_W-1:0] lane_addr;
        logic [1:0]         lane_sel;
    } rd_decode_t;

    // Linear bit address -> (lane address, lane); lane 0 = D0 ... lane 3 = D3.
    function automatic rd_decode_t rd_decode(input logic bw4, input logic [RADDR_W-1:0] addr);
        rd_decode_t d;
        if (bw4) begin
            d.lane_addr = addr[14:2];
            d.lane_sel  = ~addr[1:0];
        end else begin
            d.lane_addr = addr[13:1];
            d.lane_sel  = {1'b0, ~addr[0]};
        end
        return d;
    endfunction

endpackage

// File: rtl/bubble_inbuffer_lane.sv
// One bit-lane of the input page: 1024 x 1 simple dual-port RAM, clock-enabled registered read.
module bubble_inbuffer_lane
    import bubble_pkg::*;
(
    input  logic               MCLK,
    input  logic               wr_en,
    input  logic [LANE_AW-1:0] wr_addr,
    input  logic               wr_data,
    input  logic               rd_en,
    input  logic [LANE_AW-1:0] rd_addr,
    output logic               rd_data
);

    logic mem [LANE_DEPTH];

    always_ff @(posedge MCLK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge MCLK) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/bubble_inbuffer.sv
// Captures one bubble page per channel during a user write access and holds it
// for bit-serial draining by the SPI writer.
module bubble_inbuffer
    import bubble_pkg::*;
(
    input  logic               MCLK,
    input  logic               nRESET,
    input  logic               BITWIDTH4,
    input  logic [ACC_W-1:0]   ACCTYPE,
    input  logic [CYC_W-1:0]   BINCYCLENUM,
    input  logic               nBINCLKEN,
    input  logic               DIN0,
    input  logic               DIN1,
    input  logic               DIN2,
    input  logic               DIN3,
    input  logic               nINBUFRDCLKEN,
    input  logic [RADDR_W-1:0] INBUFRDADDR,
    output logic               INBUFRDDATA,
    output logic               INBUFRDY,
    input  logic               INBUFACK,
    output logic               INBUFOVF,
    output logic [CNT_W-1:0]   INBUFBITCNT
);

    localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(PAGE_BITS);
    localparam logic [LANE_AW-1:0] PAGE_LIMIT = LANE_AW'(PAGE_BITS);

    ibuf_state_t          state;
    ibuf_state_t          state_nxt;
    logic [CNT_W-1:0]     cnt_nxt;
    logic                 ovf_nxt;

    logic                 acc_wr_c;
    logic [LANE_AW-1:0]   page_pos_c;
    logic                 capture_c;
    logic [NUM_LANES-1:0] lane_we_c;
    logic [NUM_LANES-1:0] lane_wd_c;
    logic [NUM_LANES-1:0] lane_q;
    logic                 unused_cyc_hi_c;

    rd_decode_t           rd_dec_c;
    logic                 rd_en_c;
    logic [1:0]           rd_sel_q;
    logic                 rd_zero_q;

    assign acc_wr_c        = (ACCTYPE == USER_WR);
    assign page_pos_c      = BINCYCLENUM[LANE_AW-1:0];
    assign unused_cyc_hi_c = ^BINCYCLENUM[CYC_W-1:LANE_AW];
    assign capture_c       = (state == ST_CAPTURE) && !nBINCLKEN && (page_pos_c < PAGE_LIMIT);

    // D2/D3 lanes only take data from a 4-bit module; RAM stores positive logic.
    assign lane_we_c = {{2{capture_c & BITWIDTH4}}, {2{capture_c}}};
    assign lane_wd_c = ~{DIN3, DIN2, DIN1, DIN0};

    always_comb begin
        state_nxt = state;
        cnt_nxt   = INBUFBITCNT;
        ovf_nxt   = INBUFOVF;
        case (state)
            ST_IDLE: begin
                if (acc_wr_c) begin
                    state_nxt = ST_CAPTURE;
                    cnt_nxt   = '0;
                end
            end
            ST_CAPTURE: begin
                if (capture_c && (INBUFBITCNT != CNT_MAX)) begin
                    cnt_nxt = INBUFBITCNT + CNT_W'(1);
                end
                if (!acc_wr_c) begin
                    state_nxt = (INBUFBITCNT != '0) ? ST_HOLD : ST_IDLE;
                end
            end
            ST_HOLD: begin
                // Acknowledge wins over a colliding write access; the new access starts from IDLE.
                if (INBUFACK) begin
                    state_nxt = ST_IDLE;
                    ovf_nxt   = 1'b0;
                end else if (acc_wr_c) begin
                    ovf_nxt   = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge MCLK) begin
        if (!nRESET) begin
            state       <= ST_IDLE;
            INBUFBITCNT <= '0;
            INBUFOVF    <= 1'b0;
            INBUFRDY    <= 1'b0;
        end else begin
            state       <= state_nxt;
            INBUFBITCNT <= cnt_nxt;
            INBUFOVF    <= ovf_nxt;
            INBUFRDY    <= (state_nxt == ST_HOLD);
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        bubble_inbuffer_lane u_lane (
            .MCLK    (MCLK),
            .wr_en   (lane_we_c[i]),
            .wr_addr (page_pos_c),
            .wr_data (lane_wd_c[i]),
            .rd_en   (rd_en_c),
            .rd_addr (rd_dec_c.lane_addr[LANE_AW-1:0]),
            .rd_data (lane_q[i])
        );
    end

    assign rd_dec_c = rd_decode(BITWIDTH4, INBUFRDADDR);
    assign rd_en_c  = !nINBUFRDCLKEN;

    // Lane select and out-of-range flag are captured alongside the RAM read register.
    always_ff @(posedge MCLK) begin
        if (!nRESET) begin
            rd_sel_q  <= 2'd0;
            rd_zero_q <= 1'b1;
        end else if (rd_en_c) begin
            rd_sel_q  <= rd_dec_c.lane_sel;
            rd_zero_q <= (rd_dec_c.lane_addr[RLANE_W-1:LANE_AW] != '0);
        end
    end

    assign INBUFRDDATA = ~rd_zero_q & lane_q[rd_sel_q];

endmodule

// File: tb/tb_bubble_inbuffer.sv
// Randomized self-checking bench for bubble_inbuffer with a page-level reference model.
module tb_bubble_inbuffer;

    localparam logic [2:0] A_IDLE    = 3'b000;
    localparam logic [2:0] A_USER    = 3'b111;
    localparam logic [2:0] A_USER_WR = 3'b101;
    localparam int         PAGE      = 584;

    logic        MCLK = 1'b0;
    logic        nRESET;
    logic        BITWIDTH4;
    logic [2:0]  ACCTYPE;
    logic [12:0] BINCYCLENUM;
    logic        nBINCLKEN;
    logic        DIN0, DIN1, DIN2, DIN3;
    logic        nINBUFRDCLKEN;
    logic [14:0] INBUFRDADDR;
    logic        INBUFRDDATA;
    logic        INBUFRDY;
    logic        INBUFACK;
    logic        INBUFOVF;
    logic [9:0]  INBUFBITCNT;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference page contents per lane (positive logic); X = never written.
    logic mram [4][1024];

    bubble_inbuffer dut (
        .MCLK          (MCLK),
        .nRESET        (nRESET),
        .BITWIDTH4     (BITWIDTH4),
        .ACCTYPE       (ACCTYPE),
        .BINCYCLENUM   (BINCYCLENUM),
        .nBINCLKEN     (nBINCLKEN),
        .DIN0          (DIN0),
        .DIN1          (DIN1),
        .DIN2          (DIN2),
        .DIN3          (DIN3),
        .nINBUFRDCLKEN (nINBUFRDCLKEN),
        .INBUFRDADDR   (INBUFRDADDR),
        .INBUFRDDATA   (INBUFRDDATA),
        .INBUFRDY      (INBUFRDY),
        .INBUFACK      (INBUFACK),
        .INBUFOVF      (INBUFOVF),
        .INBUFBITCNT   (INBUFBITCNT)
    );

    always #10 MCLK = ~MCLK;

    task automatic step();
        @(posedge MCLK);
        #1;
    endtask

    // Expected read bit from the linear address rule.
    function automatic logic exp_bit(input bit bw4, input int unsigned addr);
        int unsigned la, lane;
        if (bw4) begin
            la   = addr / 4;
            lane = 3 - (addr % 4);
        end else begin
            la   = (addr % 16384) / 2;
            lane = (addr % 2 == 1) ? 0 : 1;
        end
        if (la >= 1024) return 1'b0;
        return mram[lane][la];
    endfunction

    task automatic do_read(input int unsigned addr);
        nINBUFRDCLKEN = 1'b0;
        INBUFRDADDR   = 15'(addr);
        step();
        nINBUFRDCLKEN = 1'b1;
    endtask

    // One capture tick; 'store' says whether the model expects it to land in RAM.
    task automatic drive_tick(input int unsigned pos, input logic [3:0] pins, input bit store);
        nBINCLKEN   = 1'b0;
        BINCYCLENUM = {3'($urandom), 10'(pos)};
        {DIN3, DIN2, DIN1, DIN0} = pins;
        if (store && pos < PAGE) begin
            mram[0][pos] = ~pins[0];
            mram[1][pos] = ~pins[1];
            if (BITWIDTH4) begin
                mram[2][pos] = ~pins[2];
                mram[3][pos] = ~pins[3];
            end
        end
        step();
        nBINCLKEN = 1'b1;
    endtask

    // Full page access with random gaps, out-of-range ticks and saturating extra ticks; ends in HOLD.
    task automatic run_page(input bit bw4);
        BITWIDTH4 = bw4;
        ACCTYPE   = A_USER_WR;
        step();
        for (int k = 0; k < PAGE; k++) begin
            if ($urandom_range(7) == 0) drive_tick(584 + $urandom_range(439), 4'($urandom), 1'b1);
            if ($urandom_range(3) == 0) step();
            drive_tick(k, 4'($urandom), 1'b1);
        end
        for (int k = 0; k < 5; k++) drive_tick($urandom_range(PAGE - 1), 4'($urandom), 1'b1);
        ACCTYPE = A_USER;
        step();
    endtask

    task automatic test_reset();
        nRESET = 1'b0; BITWIDTH4 = 1'b0; ACCTYPE = A_IDLE; BINCYCLENUM = '0; nBINCLKEN = 1'b1;
        {DIN3, DIN2, DIN1, DIN0} = 4'hF; nINBUFRDCLKEN = 1'b1; INBUFRDADDR = '0; INBUFACK = 1'b0;
        step(); step();
        nRESET = 1'b1;
        step();
        n_assert++; if (INBUFRDY !== 1'b0) begin n_fail++; $display("FAIL reset_rdy got=%b exp=0", INBUFRDY); end
        n_assert++; if (INBUFOVF !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", INBUFOVF); end
        n_assert++; if (INBUFBITCNT !== 10'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", INBUFBITCNT); end
        n_assert++; if (INBUFRDDATA !== 1'b0) begin n_fail++; $display("FAIL reset_rddata got=%b exp=0", INBUFRDDATA); end
    endtask

    task automatic test_capture_4bit();
        logic e, held;
        run_page(1'b1);
        n_assert++; if (INBUFRDY !== 1'b1) begin n_fail++; $display("FAIL cap4_rdy got=%b exp=1", INBUFRDY); end
        n_assert++; if (INBUFBITCNT !== 10'd584) begin n_fail++; $display("FAIL cap4_cnt got=%0d exp=584", INBUFBITCNT); end
        n_assert++; if (INBUFOVF !== 1'b0) begin n_fail++; $display("FAIL cap4_ovf got=%b exp=0", INBUFOVF); end
        for (int i = 0; i < 400; i++) begin
            int unsigned a;
            a = $urandom_range(PAGE - 1) * 4 + $urandom_range(3);
            do_read(a);
            e = exp_bit(1'b1, a);
            n_assert++; if (INBUFRDDATA !== e) begin n_fail++; $display("FAIL cap4_read addr=%0d got=%b exp=%b", a, INBUFRDDATA, e); end
            held = e;
            INBUFRDADDR = 15'($urandom);
            step();
            n_assert++; if (INBUFRDDATA !== held) begin n_fail++; $display("FAIL cap4_hold addr=%0d got=%b exp=%b", a, INBUFRDDATA, held); end
        end
        for (int i = 0; i < 8; i++) begin
            int unsigned a;
            a = 4096 + $urandom_range(28671);
            do_read(a);
            n_assert++; if (INBUFRDDATA !== 1'b0) begin n_fail++; $display("FAIL cap4_oor addr=%0d got=%b exp=0", a, INBUFRDDATA); end
        end
        INBUFACK = 1'b1; step(); INBUFACK = 1'b0;
        n_assert++; if (INBUFRDY !== 1'b0) begin n_fail++; $display("FAIL cap4_ack_rdy got=%b exp=0", INBUFRDY); end
    endtask

    task automatic test_capture_2bit();
        logic e;
        run_page(1'b0);
        n_assert++; if (INBUFRDY !== 1'b1) begin n_fail++; $display("FAIL cap2_rdy got=%b exp=1", INBUFRDY); end
        n_assert++; if (INBUFBITCNT !== 10'd584) begin n_fail++; $display("FAIL cap2_cnt got=%0d exp=584", INBUFBITCNT); end
        for (int unsigned a = 0; a < 2 * PAGE; a++) begin
            do_read(a);
            e = exp_bit(1'b0, a);
            n_assert++; if (INBUFRDDATA !== e) begin n_fail++; $display("FAIL cap2_read addr=%0d got=%b exp=%b", a, INBUFRDDATA, e); end
        end
        for (int i = 0; i < 8; i++) begin
            int unsigned a;
            a = 2048 + $urandom_range(14335) + ($urandom_range(1) * 16384);
            do_read(a);
            n_assert++; if (INBUFRDDATA !== 1'b0) begin n_fail++; $display("FAIL cap2_oor addr=%0d got=%b exp=0", a, INBUFRDDATA); end
        end
        // D2/D3 lanes must still hold the earlier 4-bit page.
        BITWIDTH4 = 1'b1;
        for (int i = 0; i < 100; i++) begin
            int unsigned a;
            a = $urandom_range(PAGE - 1) * 4 + $urandom_range(1);
            do_read(a);
            e = exp_bit(1'b1, a);
            n_assert++; if (INBUFRDDATA !== e) begin n_fail++; $display("FAIL cap2_d23_kept addr=%0d got=%b exp=%b", a, INBUFRDDATA, e); end
        end
        BITWIDTH4 = 1'b0;
    endtask

    task automatic test_overflow();
        logic e;
        ACCTYPE = A_USER_WR;
        for (int i = 0; i < 10; i++) drive_tick($urandom_range(PAGE - 1), 4'hE, 1'b0);
        n_assert++; if (INBUFOVF !== 1'b1) begin n_fail++; $display("FAIL ovf_set got=%b exp=1", INBUFOVF); end
        n_assert++; if (INBUFRDY !== 1'b1) begin n_fail++; $display("FAIL ovf_rdy got=%b exp=1", INBUFRDY); end
        n_assert++; if (INBUFBITCNT !== 10'd584) begin n_fail++; $display("FAIL ovf_cnt got=%0d exp=584", INBUFBITCNT); end
        ACCTYPE = A_USER;
        step();
        n_assert++; if (INBUFOVF !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%b exp=1", INBUFOVF); end
        for (int i = 0; i < 60; i++) begin
            int unsigned a;
            a = $urandom_range(2 * PAGE - 1);
            do_read(a);
            e = exp_bit(1'b0, a);
            n_assert++; if (INBUFRDDATA !== e) begin n_fail++; $display("FAIL ovf_page_kept addr=%0d got=%b exp=%b", a, INBUFRDDATA, e); end
        end
        INBUFACK = 1'b1; step(); INBUFACK = 1'b0;
        n_assert++; if (INBUFOVF !== 1'b0) begin n_fail++; $display("FAIL ovf_ack_clr got=%b exp=0", INBUFOVF); end
        n_assert++; if (INBUFRDY !== 1'b0) begin n_fail++; $display("FAIL ovf_ack_rdy got=%b exp=0", INBUFRDY); end
        INBUFACK = 1'b1; step(); INBUFACK = 1'b0;
        n_assert++; if (INBUFRDY !== 1'b0) begin n_fail++; $display("FAIL idle_ack_rdy got=%b exp=0", INBUFRDY); end
    endtask

    task automatic test_back_to_back();
        ACCTYPE = A_USER_WR;
        step();
        for (int i = 0; i < 20; i++) drive_tick($urandom_range(PAGE - 1), 4'($urandom), 1'b1);
        ACCTYPE = A_IDLE;
        step();
        n_assert++; if (INBUFRDY !== 1'b1) begin n_fail++; $display("FAIL b2b_rdy got=%b exp=1", INBUFRDY); end
        n_assert++; if (INBUFBITCNT !== 10'd20) begin n_fail++; $display("FAIL b2b_cnt got=%0d exp=20", INBUFBITCNT); end
        ACCTYPE = A_USER_WR; INBUFACK = 1'b1;
        step();
        INBUFACK = 1'b0;
        n_assert++; if (INBUFRDY !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_rdy got=%b exp=0", INBUFRDY); end
        n_assert++; if (INBUFOVF !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf got=%b exp=0", INBUFOVF); end
        step();
        n_assert++; if (INBUFBITCNT !== 10'd0) begin n_fail++; $display("FAIL b2b_cnt_clr got=%0d exp=0", INBUFBITCNT); end
        drive_tick($urandom_range(PAGE - 1), 4'($urandom), 1'b1);
        n_assert++; if (INBUFBITCNT !== 10'd1) begin n_fail++; $display("FAIL b2b_cnt_one got=%0d exp=1", INBUFBITCNT); end
        ACCTYPE = A_IDLE;
        step();
        n_assert++; if (INBUFRDY !== 1'b1) begin n_fail++; $display("FAIL b2b_hold2 got=%b exp=1", INBUFRDY); end
        INBUFACK = 1'b1; step(); INBUFACK = 1'b0;
    endtask

    task automatic test_empty_and_reset();
        ACCTYPE = A_USER_WR;
        step(); step();
        ACCTYPE = A_USER;
        step();
        n_assert++; if (INBUFRDY !== 1'b0) begin n_fail++; $display("FAIL empty_rdy got=%b exp=0", INBUFRDY); end
        step();
        n_assert++; if (INBUFRDY !== 1'b0) begin n_fail++; $display("FAIL empty_rdy_late got=%b exp=0", INBUFRDY); end
        ACCTYPE = A_USER_WR;
        step();
        for (int i = 0; i < 100; i++) drive_tick($urandom_range(PAGE - 1), 4'($urandom), 1'b1);
        n_assert++; if (INBUFBITCNT !== 10'd100) begin n_fail++; $display("FAIL rst_pre_cnt got=%0d exp=100", INBUFBITCNT); end
        nRESET = 1'b0;
        step();
        n_assert++; if (INBUFBITCNT !== 10'd0) begin n_fail++; $display("FAIL rst_cnt got=%0d exp=0", INBUFBITCNT); end
        n_assert++; if (INBUFRDY !== 1'b0) begin n_fail++; $display("FAIL rst_rdy got=%b exp=0", INBUFRDY); end
        n_assert++; if (INBUFRDDATA !== 1'b0) begin n_fail++; $display("FAIL rst_rddata got=%b exp=0", INBUFRDDATA); end
        nRESET = 1'b1; ACCTYPE = A_IDLE;
        step(); step();
        n_assert++; if (INBUFRDY !== 1'b0) begin n_fail++; $display("FAIL rst_after_rdy got=%b exp=0", INBUFRDY); end
    endtask

    initial begin
        test_reset();
        test_capture_4bit();
        test_capture_2bit();
        test_overflow();
        test_back_to_back();
        test_empty_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/bubble_inbuffer.md
Name: bubble_inbuffer

Overview:
- Write-direction counterpart of the bubble output buffer.
- Captures the host's bubble input bits (DIN0..DIN3) on nBINCLKEN ticks during a user-page write access, and stores one page per channel in 4 x 1024 x 1 block RAM.
- Once the access ends, holds the page and presents it bit-serially to the SPI writer through a 15-bit linear address, with a ready/ack handshake.

Parameters:
- PAGE_BITS, 584, number of bit positions captured per channel per page access.
- LANE_AW, 10, address width of each per-channel RAM (1024 entries).

Ports:
- MCLK, in, 1, 48 MHz system clock.
- nRESET, in, 1, synchronous active-low reset, sampled on rising MCLK.
- BITWIDTH4, in, 1, 0 = 2-bit module (D0/D1 only), 1 = 4-bit module.
- ACCTYPE, in, 3, access type from the timing generator; capture only when equal to USER_WR.
- BINCYCLENUM, in, 13, bubble input cycle number; bits [9:0] index the page position.
- nBINCLKEN, in, 1, active-low single-cycle capture tick.
- DIN0..DIN3, in, 1 each, bubble data inputs, active low on the pins.
- nINBUFRDCLKEN, in, 1, active-low read enable from the SPI writer.
- INBUFRDADDR, in, 15, linear bit read address.
- INBUFRDDATA, out, 1, registered read data.
- INBUFRDY, out, 1, page captured and held for draining.
- INBUFACK, in, 1, single-cycle pulse from the SPI writer: drain complete.
- INBUFOVF, out, 1, sticky flag: a write access arrived while a page was held.
- INBUFBITCNT, out, 10, number of capture ticks accepted in the current or held page.

Behaviour:
- Reset values: state IDLE; INBUFRDY = 0, INBUFOVF = 0, INBUFBITCNT = 0, INBUFRDDATA = 0. RAM contents are not cleared.
- FSM states: IDLE, CAPTURE, HOLD.
  - IDLE -> CAPTURE when ACCTYPE == USER_WR.
  - CAPTURE -> HOLD when ACCTYPE != USER_WR and INBUFBITCNT != 0.
  - CAPTURE -> IDLE when ACCTYPE != USER_WR and INBUFBITCNT == 0.
  - HOLD -> IDLE on INBUFACK = 1.
- Counter clears on the IDLE -> CAPTURE transition.
- Capture occurs only in CAPTURE, on a cycle with nBINCLKEN = 0 and BINCYCLENUM[9:0] < PAGE_BITS.
  - Lane address = BINCYCLENUM[9:0].
  - Stored bit = ~DINn (the RAM holds positive logic).
  - D0 and D1 are always written. D2 and D3 are written only if BITWIDTH4 = 1.
  - INBUFBITCNT increments by 1 per accepted tick and saturates at PAGE_BITS.
- Ticks with BINCYCLENUM[9:0] >= PAGE_BITS are ignored: no write, no count.
- Ticks in IDLE or HOLD never write the RAM.
- INBUFRDY = 1 exactly while in HOLD (registered output).
- ACCTYPE == USER_WR while in HOLD: set INBUFOVF, stay in HOLD, do not capture; the held page is protected.
- INBUFACK in HOLD clears INBUFOVF.
- INBUFACK outside HOLD is ignored.
- INBUFACK and ACCTYPE == USER_WR in the same cycle while in HOLD: go to IDLE with no OVF set; enter CAPTURE on the next cycle.
- Read decode (mirror of the output-buffer write decode):
  - 2-bit mode: lane address = INBUFRDADDR[13:1]; addr[0] = 0 selects D1, addr[0] = 1 selects D0.
  - 4-bit mode: lane address = INBUFRDADDR[14:2]; addr[1:0] = 00 selects D3, 01 selects D2, 10 selects D1, 11 selects D0.
  - Lane addresses beyond 1023 read 0.
- Read latency: INBUFRDDATA updates on the MCLK edge where nINBUFRDCLKEN = 0, i.e. 1 cycle; otherwise it holds.
  - Reads are legal in every state; data is guaranteed only in HOLD.
- Reset asserted mid-CAPTURE or mid-HOLD returns to IDLE immediately. A partial page is discarded logically (INBUFRDY stays 0).

Decomposition:
- Shared package bubble_pkg holds:
  - ACCTYPE constants BOOT = 3'b110, USER = 3'b111, USER_WR = 3'b101.
  - PAGE_BITS = 584.
  - FSM state encoding.
- One natural sub-module: bubble_inbuffer_lane, a 1024 x 1 simple dual-port RAM with write enable and registered, clock-enabled read. Instantiate it four times.

Test Plan:
- 2-bit capture/drain: BITWIDTH4 = 0, USER_WR for 584 ticks with DIN0 = ~cycle[0] and DIN1 = 1 (pins active low), then ACCTYPE = IDLE -> INBUFRDY = 1 and INBUFBITCNT = 584. Reading addr 2k+1 returns k[0]; reading addr 2k returns 0; each read has 1-cycle latency.
- Out-of-range ticks: ticks at BINCYCLENUM[9:0] = 584..1023 -> no RAM change, INBUFBITCNT stays 584.
- Overflow: in HOLD, drive ACCTYPE = USER_WR with 10 ticks of DIN0 = 0 -> INBUFOVF = 1 and the held page reads unchanged. INBUFACK then clears OVF and RDY and returns the FSM to IDLE.
- Simultaneous ACK + USER_WR: both in the same HOLD cycle -> OVF stays 0, FSM goes IDLE then CAPTURE, counter = 0.
- Empty access and reset: USER_WR entered and left with no ticks -> returns to IDLE, INBUFRDY never rises. nRESET = 0 mid-capture after 100 ticks -> INBUFBITCNT = 0, INBUFRDY = 0 on the next cycle.
- 4-bit mode: BITWIDTH4 = 1 with distinct patterns on DIN0..3 -> addr 4k+0/1/2/3 returns D3/D2/D1/D0 bit k respectively.
